// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity serial link: FSM state encodings,
// line levels and frame geometry.
package odd_parity_pkg;

  // Transmit FSM states; 3-bit encoding leaves room for future states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Start, parity and stop surround the data bits.
  localparam int unsigned FRAME_OVERHEAD = 3;

  // Number of bit periods in one frame (FRAME_BITS = DATA_W + 3).
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/odd_parity_generator.sv
// Combinational odd-parity generator: p makes the XOR of data and p equal 1.
module odd_parity_generator #(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  output logic              p
);

  assign p = ~^data;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial transmitter. Accepts a word on a valid/ready handshake and
// sends start, data LSB-first, odd parity and stop, each held BIT_CYCLES clocks.
// All outputs come straight from registers.
module odd_parity_serial_tx #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              par_out,
  output logic              busy,
  output logic              done
);

  import odd_parity_pkg::*;

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned CYC_CNT_W = $clog2(BIT_CYCLES + 1);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [CYC_CNT_W-1:0] CYC_LAST = CYC_CNT_W'(BIT_CYCLES - 1);

  if (DATA_W < 1) begin : gen_bad_data_w
    $error("DATA_W must be at least 1");
  end
  if (BIT_CYCLES < 1) begin : gen_bad_bit_cycles
    $error("BIT_CYCLES must be at least 1");
  end

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_q,   bit_d;
  logic [CYC_CNT_W-1:0]   cyc_q,   cyc_d;
  logic                   tx_q,    tx_d;
  logic                   par_q,   par_d;
  logic                   ready_q, ready_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;

  logic                   gen_p;
  logic                   accept;
  logic                   period_end;
  logic [DATA_W-1:0]      shift_next;

  odd_parity_generator #(
    .DATA_W (DATA_W)
  ) u_gen (
    .data (in_data),
    .p    (gen_p)
  );

  assign accept     = (state_q == ST_IDLE) && in_valid && ready_q;
  assign period_end = (cyc_q == CYC_LAST);
  assign shift_next = shift_q >> 1;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    tx_d    = tx_q;
    par_d   = par_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (accept) begin
          shift_d = in_data;
          par_d   = gen_p;
          state_d = ST_START;
          tx_d    = START_BIT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (period_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (period_end) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
            bit_d   = '0;
          end else begin
            // Present the next data bit as the register shifts right.
            shift_d = shift_next;
            tx_d    = shift_next[0];
            bit_d   = bit_q + BIT_CNT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (period_end) begin
          state_d = ST_STOP;
          tx_d    = STOP_BIT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (period_end) begin
          state_d = ST_IDLE;
          tx_d    = LINE_IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cyc_d = cyc_q + CYC_CNT_W'(1);
        end
      end

      default: begin
        // Illegal encoding: return to a clean idle line.
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      tx_q    <= LINE_IDLE;
      par_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      tx_q    <= tx_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign tx       = tx_q;
  assign par_out  = par_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
